// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    KILL
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifu_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/ifu_imem_if.sv
// Instruction memory request/response bus, one outstanding request.
interface ifu_imem_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/ifu_fifo2.sv
// Two-entry {pc, instr} prefetch FIFO with flush.
module ifu_fifo2
  import ifu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  ifu_entry_t wdata,
  output ifu_entry_t head,
  output logic [1:0] count
);

  ifu_entry_t mem_q [2];
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic [1:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  always_comb begin
    do_push = push && ((cnt_q != 2'd2) || pop);
    do_pop  = pop && (cnt_q != 2'd0);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      rd_d  = 1'b0;
      wr_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (do_push) wr_d = ~wr_q;
      if (do_pop)  rd_d = ~rd_q;
      cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (do_push && !flush) mem_q[wr_q] <= wdata;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: fetch PC, single-outstanding imem requests, 2-entry prefetch.
// Optional IFU_ALIGN_CHECK_EN flags misaligned redirect targets.
module if_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  ifu_imem_if.master  imem,
  output logic        ifu_valid,
  output logic [31:0] ifu_pc,
  output logic [31:0] ifu_instr,
  output logic        ifu_misalign
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rpc_q, rpc_d;
  logic [1:0]  cnt;
  ifu_entry_t  head;
  ifu_entry_t  wentry;
  logic        rsp, push, pop, issue;
  logic [2:0]  occ;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rpc_d   = rpc_q;
    rsp     = imem.imem_rvalid && (state_q == WAIT);
    push    = rsp && !redirect_valid;
    pop     = (cnt != 2'd0) && !stall && !redirect_valid;
    occ     = {1'b0, cnt} + {2'b0, push} - {2'b0, pop};
    issue   = ((state_q == REQ) || rsp) && !redirect_valid
              && (occ <= 3'd1) && !rst;

    unique case (state_q)
      REQ:  if (issue) state_d = WAIT;
      WAIT: begin
        if (imem.imem_rvalid) state_d = issue ? WAIT : REQ;
        else if (redirect_valid) state_d = KILL;
      end
      KILL: if (imem.imem_rvalid) state_d = REQ;
      default: state_d = REQ;
    endcase

    // redirect wins over the sequential increment
    if (redirect_valid) pc_d = word_align(redirect_pc);
    else if (issue) pc_d = pc_q + 32'd4;
    if (issue) rpc_d = pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= REQ;
      pc_q    <= word_align(RESET_PC);
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
    end
  end

  assign wentry = '{pc: rpc_q, instr: imem.imem_rdata};

  ifu_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wentry),
    .head  (head),
    .count (cnt)
  );

  assign imem.imem_req  = issue;
  assign imem.imem_addr = issue ? pc_q : '0;

  assign ifu_valid = (cnt != 2'd0);
  assign ifu_pc    = ifu_valid ? head.pc : '0;
  assign ifu_instr = ifu_valid ? head.instr : NOP_INSTR;

`ifdef IFU_ALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_q <= 1'b0;
    else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) mis_q <= 1'b1;
  end

  assign ifu_misalign = mis_q;
`else
  assign ifu_misalign = 1'b0;
`endif

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage of the 5-stage RISC-V pipeline. It sits directly upstream of the IF/ID register. It owns the fetch PC and issues word requests to instruction memory, accepting one outstanding request and variable response latency. Returned words are buffered in a 2-entry prefetch FIFO. When no instruction is ready it presents a NOP bubble so that IF/ID never duplicates a held instruction.

## Interface
Parameters:
- RESET_PC, 32'h0, fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; rst is asynchronous, active-high; clock clk.
- stall  in  1  hazard-unit stall; when high, the IF/ID register does not load.
- redirect_valid  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  32  new fetch target.
- imem_req  out  1  request strobe; accepted in the cycle it is high.
- imem_addr  out  32  word address; valid while imem_req is high.
- imem_rvalid  in  1  response strobe; arrives 1 or more cycles after the request.
- imem_rdata  in  32  instruction word; valid while imem_rvalid is high.
- ifu_valid  out  1  FIFO head is a real instruction.
- ifu_pc  out  32  head PC; 32'h0 when !ifu_valid.
- ifu_instr  out  32  head instruction; 32'h00000013 when !ifu_valid.
- ifu_misalign  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- Fetch PC register pc_f:
  - Increments by 4 for each issued request.
  - Wraps from 32'hFFFFFFFC to 32'h0.
  - Bits [1:0] are always 0.
- FSM states:
  - REQ: may issue a request.
  - WAIT: one request outstanding.
  - KILL: one request outstanding whose response must be discarded.
- FSM transitions:
  - REQ → WAIT when a request is issued.
  - WAIT → REQ on imem_rvalid; the response is written into the FIFO.
  - WAIT → KILL on redirect_valid without imem_rvalid in the same cycle.
  - KILL → REQ on imem_rvalid; the response is dropped.
- Issue rule: in REQ, or in WAIT in a cycle with imem_rvalid, assert imem_req with imem_addr=pc_f when both hold:
  - the FIFO occupancy after this cycle's write and pop is at most 1;
  - redirect_valid is low.
- Pop rule: the head is popped when ifu_valid && !stall && !redirect_valid.
- Redirect:
  - Flushes the FIFO and sets pc_f to redirect_pc with bits [1:0] forced to 0.
  - Redirect has priority over pop, over FIFO write, and over issue in that cycle.
  - A response arriving in the redirect cycle is dropped.
  - A redirect while in KILL updates pc_f and the FSM stays in KILL.
- An imem_rvalid arriving in REQ is ignored.

## Timing
- Reset values:
  - imem_req=0, imem_addr=0.
  - ifu_valid=0, ifu_pc=0, ifu_instr=32'h00000013.
  - ifu_misalign=0.
  - pc_f=RESET_PC, FSM in REQ, FIFO empty.
- First request is issued in the first clock after rst deasserts.
- Response latency:
  - A response written at edge E appears on ifu_* after E; there is no same-cycle bypass.
  - With 1-cycle memory latency, a request at cycle N gives ifu_valid in cycle N+2.
- Throughput:
  - With 1-cycle latency, one instruction per cycle in steady state (back-to-back issue in WAIT on rvalid).
  - With k-cycle latency, one instruction per k cycles.
- Full FIFO (2 entries): no issue.
- Empty FIFO: bubble on ifu_*.
- Redirect at cycle N:
  - Bubble on ifu_* from N+1.
  - First request to the new target at N+1 (REQ), or in the cycle after the killed response (KILL).
- rst asserted mid-operation clears everything immediately. Responses to pre-reset requests are ignored because the FSM is in REQ.

## Configuration
- IFU_ALIGN_CHECK_EN defined: a redirect_pc with bits [1:0]≠0 sets ifu_misalign. The flag stays set until rst. The PC is still forced to word alignment.
- Undefined: low bits are masked silently, and ifu_misalign is tied to 0.

## Structure
- Shared package ifu_pkg holds:
  - NOP_INSTR = 32'h00000013;
  - the FSM state enum (REQ, WAIT, KILL);
  - the default RESET_PC.
- One sub-module, ifu_fifo2: 2-entry {pc, instr} FIFO with push, pop, flush, count, and head outputs.

## Test plan
- Reset with 1-cycle memory: imem_addr sequence 0, 4, 8 on consecutive cycles; ifu_valid from cycle 2, then ifu_pc 0, 4, 8, one per cycle.
- stall held 4 cycles: FIFO fills to 2, imem_req stops, and ifu_pc holds. After release, consecutive PCs follow with no gap and no duplicate.
- 3-cycle latency, redirect to 32'h100 while in WAIT: the in-flight word is dropped (KILL). The next request is 32'h100 and the next valid ifu_pc is 32'h100.
- Redirect in the same cycle as imem_rvalid: the word is not enqueued, the next ifu_pc is the target, and no KILL cycle occurs.
- Redirect to 32'hFFFFFFFC: fetches 32'hFFFFFFFC, then 32'h0.
- Redirect to 32'h102 with IFU_ALIGN_CHECK_EN: the fetch goes to 32'h100 and ifu_misalign=1 until rst. Without the macro, ifu_misalign stays 0.
